// File: rtl/axi_pkg.sv
// Shared AXI response/size codes, FSM state types and decode helpers for axi_mem_slave.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Ports: none (package).
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] SIZE_B = 3'b000;
   localparam logic [2:0] SIZE_W = 3'b010;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_READ = 2'd1,
      RD_RESP = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_COMMIT = 2'd1,
      WR_RESP   = 2'd2
   } wr_state_t;

   // Out-of-range address wins over malformed-transfer errors.
   function automatic logic [1:0] decode_resp(input logic       in_range,
                                              input logic [7:0] len,
                                              input logic [2:0] size,
                                              input logic       last);
      logic [1:0] resp;
      resp = RESP_OKAY;
      if (!in_range) begin
         resp = RESP_DECERR;
      end else if ((len != 8'd0) || ((size != SIZE_B) && (size != SIZE_W)) || !last) begin
         resp = RESP_SLVERR;
      end
      return resp;
   endfunction

   // Pick byte lane from a little-endian word and sign-extend it to 32 bits.
   function automatic logic [31:0] sext_byte(input logic [31:0] word,
                                             input logic [1:0]  lane);
      logic [7:0] b;
      b = word[8*lane +: 8];
      return {{24{b[7]}}, b};
   endfunction

endpackage

// File: rtl/axi_mem_slave_sdp_ram.sv
// Simple dual-port 32-bit x DEPTH RAM: one byte-enabled write port, one registered read port.
// Latency: read data valid the cycle after rd_en is sampled; same-address write on that edge returns old data.
// Backpressure: none; rd_dat holds its value while rd_en is low.
// Ports: clk; wr_en/wr_addr/wr_be/wr_dat write port; rd_en/rd_addr read request; rd_dat read data.
module sdp_ram #(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [3:0]    wr_be,
   input  logic [31:0]   wr_dat,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_dat
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rd_dat_q;

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
               mem_q[wr_addr][8*b +: 8] <= wr_dat[8*b +: 8];
            end
         end
      end
   end

   // Non-blocking read of mem_q gives read-before-write on a same-edge collision.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_dat_q <= mem_q[rd_addr];
      end
   end

   assign rd_dat = rd_dat_q;

endmodule

// File: rtl/axi_mem_slave.sv
// Single-beat AXI4 memory responder (LB/LW/SB/SW) over a word-organised on-chip RAM.
// Latency: AR or AW+W handshake at edge N -> rvalid/bvalid high after edge N+2.
// Backpressure: one outstanding per channel; R/B held stable until rready/bready, address readies low meanwhile.
// Ports: clk, rstn; AR (araddr/arid/arlen/arsize/arvalid/arready); R (rdata/rid/rlast/rresp/rvalid/rready);
//        AW (awaddr/awid/awlen/awsize/awvalid/awready); W (wdata/wstrb/wlast/wvalid/wready); B (bid/bresp/bvalid/bready).
module axi_mem_slave
   import axi_pkg::*;
#(
   parameter int ADDR_W = 31,
   parameter int DATA_W = 512,
   parameter int ID_W   = 4,
   parameter int DEPTH  = 4096
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [ID_W-1:0]     arid,
   input  logic [7:0]          arlen,
   input  logic [2:0]          arsize,
   input  logic                arvalid,
   output logic                arready,
   output logic [DATA_W-1:0]   rdata,
   output logic [ID_W-1:0]     rid,
   output logic                rlast,
   output logic [1:0]          rresp,
   output logic                rvalid,
   input  logic                rready,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [ID_W-1:0]     awid,
   input  logic [7:0]          awlen,
   input  logic [2:0]          awsize,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   input  logic                wvalid,
   output logic                wready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready
);

   localparam int IDX_W = $clog2(DEPTH);

   // ---------------- read channel state ----------------
   rd_state_t         rd_state_q, rd_state_d;
   logic              ar_rdy_q, ar_rdy_d;
   logic              ar_held_q, ar_held_d;
   logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
   logic [ID_W-1:0]   ar_id_q, ar_id_d;
   logic [7:0]        ar_len_q, ar_len_d;
   logic [2:0]        ar_size_q, ar_size_d;
   logic              rvalid_q, rvalid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic [1:0]        rresp_q, rresp_d;

   // ---------------- write channel state ----------------
   wr_state_t         wr_state_q, wr_state_d;
   logic              aw_rdy_q, aw_rdy_d;
   logic              aw_held_q, aw_held_d;
   logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic [ID_W-1:0]   aw_id_q, aw_id_d;
   logic [7:0]        aw_len_q, aw_len_d;
   logic [2:0]        aw_size_q, aw_size_d;
   logic              w_rdy_q, w_rdy_d;
   logic              w_held_q, w_held_d;
   logic [31:0]       w_dat_q, w_dat_d;
   logic [3:0]        w_strb_q, w_strb_d;
   logic              w_last_q, w_last_d;
   logic              bvalid_q, bvalid_d;
   logic [ID_W-1:0]   bid_q, bid_d;
   logic [1:0]        bresp_q, bresp_d;

   // ---------------- RAM interface ----------------
   logic              ram_rd_en;
   logic [31:0]       ram_rd_dat;
   logic              ram_wr_en;
   logic [3:0]        ram_wr_be;
   logic [31:0]       ram_wr_dat;

   logic              ar_in_range, aw_in_range;
   logic [1:0]        rd_resp, wr_resp;
   logic [31:0]       rd_fmt;

   // Only the low payload lanes are architecturally meaningful.
   logic              unused_wide;
   assign unused_wide = ^{wdata[DATA_W-1:32], wstrb[DATA_W/8-1:4]};

   // Word index in range iff every index bit above the RAM index is zero (DEPTH is a power of two).
   assign ar_in_range = (ar_addr_q[ADDR_W-1:IDX_W+2] == '0);
   assign aw_in_range = (aw_addr_q[ADDR_W-1:IDX_W+2] == '0);

   assign rd_resp = decode_resp(ar_in_range, ar_len_q, ar_size_q, 1'b1);
   assign wr_resp = decode_resp(aw_in_range, aw_len_q, aw_size_q, w_last_q);

   assign rd_fmt  = (ar_size_q == SIZE_B) ? sext_byte(ram_rd_dat, ar_addr_q[1:0]) : ram_rd_dat;

   // Byte stores replicate the byte and enable only the addressed lane; wstrb is ignored.
   assign ram_wr_be  = (aw_size_q == SIZE_B) ? (4'b0001 << aw_addr_q[1:0]) : w_strb_q;
   assign ram_wr_dat = (aw_size_q == SIZE_B) ? {4{w_dat_q[7:0]}} : w_dat_q;

   sdp_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_wr_en),
      .wr_addr (aw_addr_q[IDX_W+1:2]),
      .wr_be   (ram_wr_be),
      .wr_dat  (ram_wr_dat),
      .rd_en   (ram_rd_en),
      .rd_addr (ar_addr_q[IDX_W+1:2]),
      .rd_dat  (ram_rd_dat)
   );

   // ---------------- read FSM ----------------
   // IDLE accepts AR into holding registers; the RAM read is launched on the
   // following edge (entering READ) and the formatted result is registered on
   // the edge leaving READ, giving rvalid after handshake edge + 2.
   always_comb begin
      rd_state_d = rd_state_q;
      ar_rdy_d   = ar_rdy_q;
      ar_held_d  = ar_held_q;
      ar_addr_d  = ar_addr_q;
      ar_id_d    = ar_id_q;
      ar_len_d   = ar_len_q;
      ar_size_d  = ar_size_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rid_d      = rid_q;
      rresp_d    = rresp_q;
      ram_rd_en  = 1'b0;
      case (rd_state_q)
         RD_IDLE: begin
            if (ar_held_q) begin
               ram_rd_en  = 1'b1;
               ar_held_d  = 1'b0;
               rd_state_d = RD_READ;
            end else if (arvalid && ar_rdy_q) begin
               ar_addr_d = araddr;
               ar_id_d   = arid;
               ar_len_d  = arlen;
               ar_size_d = arsize;
               ar_held_d = 1'b1;
               ar_rdy_d  = 1'b0;
            end else begin
               ar_rdy_d = 1'b1;
            end
         end
         RD_READ: begin
            rvalid_d   = 1'b1;
            rid_d      = ar_id_q;
            rresp_d    = rd_resp;
            rdata_d    = (rd_resp == RESP_OKAY) ? rd_fmt : 32'd0;
            rd_state_d = RD_RESP;
         end
         RD_RESP: begin
            if (rready) begin
               rvalid_d   = 1'b0;
               ar_rdy_d   = 1'b1;
               rd_state_d = RD_IDLE;
            end
         end
         default: begin
            rd_state_d = RD_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_state_q <= RD_IDLE;
         ar_rdy_q   <= 1'b0;
         ar_held_q  <= 1'b0;
         ar_addr_q  <= '0;
         ar_id_q    <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rid_q      <= '0;
         rresp_q    <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         ar_rdy_q   <= ar_rdy_d;
         ar_held_q  <= ar_held_d;
         ar_addr_q  <= ar_addr_d;
         ar_id_q    <= ar_id_d;
         ar_len_q   <= ar_len_d;
         ar_size_q  <= ar_size_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rid_q      <= rid_d;
         rresp_q    <= rresp_d;
      end
   end

   // ---------------- write FSM ----------------
   // AW and W are latched independently; once both are held the RAM is written
   // on the edge that enters COMMIT (only for OKAY), and B is raised one edge later.
   always_comb begin
      wr_state_d = wr_state_q;
      aw_rdy_d   = aw_rdy_q;
      aw_held_d  = aw_held_q;
      aw_addr_d  = aw_addr_q;
      aw_id_d    = aw_id_q;
      aw_len_d   = aw_len_q;
      aw_size_d  = aw_size_q;
      w_rdy_d    = w_rdy_q;
      w_held_d   = w_held_q;
      w_dat_d    = w_dat_q;
      w_strb_d   = w_strb_q;
      w_last_d   = w_last_q;
      bvalid_d   = bvalid_q;
      bid_d      = bid_q;
      bresp_d    = bresp_q;
      ram_wr_en  = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            if (aw_held_q && w_held_q) begin
               ram_wr_en  = (wr_resp == RESP_OKAY);
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               wr_state_d = WR_COMMIT;
            end else begin
               if (awvalid && aw_rdy_q) begin
                  aw_addr_d = awaddr;
                  aw_id_d   = awid;
                  aw_len_d  = awlen;
                  aw_size_d = awsize;
                  aw_held_d = 1'b1;
               end
               if (wvalid && w_rdy_q) begin
                  w_dat_d  = wdata[31:0];
                  w_strb_d = wstrb[3:0];
                  w_last_d = wlast;
                  w_held_d = 1'b1;
               end
               aw_rdy_d = !aw_held_d;
               w_rdy_d  = !w_held_d;
            end
         end
         WR_COMMIT: begin
            bvalid_d   = 1'b1;
            bid_d      = aw_id_q;
            bresp_d    = wr_resp;
            wr_state_d = WR_RESP;
         end
         WR_RESP: begin
            if (bready) begin
               bvalid_d   = 1'b0;
               aw_rdy_d   = 1'b1;
               w_rdy_d    = 1'b1;
               wr_state_d = WR_IDLE;
            end
         end
         default: begin
            wr_state_d = WR_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_state_q <= WR_IDLE;
         aw_rdy_q   <= 1'b0;
         aw_held_q  <= 1'b0;
         aw_addr_q  <= '0;
         aw_id_q    <= '0;
         aw_len_q   <= '0;
         aw_size_q  <= '0;
         w_rdy_q    <= 1'b0;
         w_held_q   <= 1'b0;
         w_dat_q    <= '0;
         w_strb_q   <= '0;
         w_last_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bid_q      <= '0;
         bresp_q    <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         aw_rdy_q   <= aw_rdy_d;
         aw_held_q  <= aw_held_d;
         aw_addr_q  <= aw_addr_d;
         aw_id_q    <= aw_id_d;
         aw_len_q   <= aw_len_d;
         aw_size_q  <= aw_size_d;
         w_rdy_q    <= w_rdy_d;
         w_held_q   <= w_held_d;
         w_dat_q    <= w_dat_d;
         w_strb_q   <= w_strb_d;
         w_last_q   <= w_last_d;
         bvalid_q   <= bvalid_d;
         bid_q      <= bid_d;
         bresp_q    <= bresp_d;
      end
   end

   // ---------------- outputs ----------------
   assign arready = ar_rdy_q;
   assign rvalid  = rvalid_q;
   assign rlast   = rvalid_q;
   assign rid     = rid_q;
   assign rresp   = rresp_q;
   assign rdata   = {{(DATA_W-32){1'b0}}, rdata_q};
   assign awready = aw_rdy_q;
   assign wready  = w_rdy_q;
   assign bvalid  = bvalid_q;
   assign bid     = bid_q;
   assign bresp   = bresp_q;

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4 responder: the memory-side end of the single-beat AXI interface the exec unit drives for LB/LW/SB/SW.
- Holds a word-organised on-chip memory.
- Independent read and write channels, one outstanding transaction per channel.
- Returns data in the low lanes of the 512-bit bus and reports OKAY/SLVERR/DECERR.

Parameters:
- ADDR_W, 31, byte-address width.
- DATA_W, 512, bus data width; only bits [31:0] carry payload.
- ID_W, 4, transaction ID width.
- DEPTH, 4096, memory depth in 32-bit words; power of two.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- araddr  in  ADDR_W  read byte address
- arid  in  ID_W  read ID
- arlen  in  8  burst length-1; only 0 supported
- arsize  in  3  3'b000 byte, 3'b010 word
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rdata  out  DATA_W  read data
- rid  out  ID_W  echoed arid
- rlast  out  1  always 1 with rvalid
- rresp  out  2  read response
- rvalid  out  1  R valid
- rready  in  1  R ready
- awaddr  in  ADDR_W  write byte address
- awid  in  ID_W  write ID
- awlen  in  8  only 0 supported
- awsize  in  3  3'b000 byte, 3'b010 word
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wdata  in  DATA_W  write data; [31:0] used
- wstrb  in  DATA_W/8  byte strobes; [3:0] used
- wlast  in  1  must be 1
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  ID_W  echoed awid
- bresp  out  2  write response
- bvalid  out  1  B valid
- bready  in  1  B ready
- The *burst/*cache/*lock/*prot/*qos signals are not ports; the top level leaves them unconnected.

Behaviour:
- Reset: rstn low asynchronously clears every output to 0 and forces both FSMs to IDLE.
- Memory contents are not reset. arready, awready and wready rise on the first clk edge after rstn goes high.
- Address decode: word index = addr[ADDR_W-1:2]; little-endian lanes.
  - DECERR (2'b11) if index >= DEPTH.
  - SLVERR (2'b10) if len != 0, size is not 0 or 2, or (write) wlast == 0.
  - Otherwise OKAY (2'b00).
- Read FSM, IDLE -> READ -> RESP:
  - IDLE: arready=1. On arvalid&arready, capture addr/id/size/len, drop arready, go to READ.
  - READ: memory read issued, 1 cycle.
  - RESP: rvalid=1, rlast=1, rid=captured id; rdata, rresp held stable until rready.
  - On rvalid&rready, go to IDLE with arready=1 the next cycle.
  - Latency: AR handshake at edge N -> rvalid high after edge N+2. rready already high gives a 3-cycle read turnaround.
- rdata content:
  - Word: mem word in [31:0].
  - Byte: lane addr[1:0] sign-extended to [31:0].
  - Bits [DATA_W-1:32] always 0.
  - Error responses return rdata = 0.
- Write FSM, IDLE -> COMMIT -> RESP:
  - IDLE: awready and wready start at 1. AW and W are captured independently, in either order or in the same cycle; each ready drops once its channel is captured.
  - When both are held, go to COMMIT and write memory on that edge.
    - Word: bytes enabled by wstrb[3:0].
    - Byte: wdata[7:0] written to lane addr[1:0]; wstrb ignored.
  - Error responses write nothing.
  - RESP: bvalid=1, bid, bresp held until bready. Then IDLE with awready=wready=1 next cycle.
- Simultaneous read and write:
  - The channels run concurrently on the two ports of the sub-RAM.
  - A READ and a COMMIT to the same word on the same edge returns the old data.
- Reset mid-operation:
  - Pending responses are lost.
  - A write whose COMMIT edge has passed stays in memory; otherwise nothing is written.
- Valid/data outputs never change while valid is high and ready is low.

Decomposition:
- Package axi_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - SIZE_B=3'b000, SIZE_W=3'b010
  - Read and write FSM state enums.
- Sub-module sdp_ram: simple dual-port 32-bit x DEPTH memory.
  - One write port with 4-bit byte enable.
  - One registered read port, 1-cycle latency.

Test Plan:
- Word write/read: SW awaddr=0x100, wdata=0xDEADBEEF, wstrb=0xF, AW and W in the same cycle -> bresp=00, bvalid 2 edges after handshake. Then LW 0x100 -> rdata[31:0]=0xDEADBEEF, rlast=1, rresp=00, upper bits 0.
- Byte write/read: SB 0x103 with wdata[7:0]=0x80 over word 0x11223344 -> word reads 0x80223344. LB 0x103 -> rdata=0xFFFFFF80.
- Decoupled AW/W: W presented 5 cycles before AW -> wready drops after W capture, no B until AW arrives, then bresp=00 and memory updated.
- Errors:
  - LW at word index DEPTH -> rresp=11, rdata=0.
  - arlen=3 -> rresp=10, single beat with rlast=1.
  - awlen=1 write -> bresp=10, memory unchanged.
- Backpressure and ID: hold rready/bready low 10 cycles -> rvalid/bvalid, data and rid/bid (arid=5/awid=9) stay stable; arready stays low.
- Reset mid-read: assert rstn during READ -> rvalid=0 and arready=0 immediately; arready=1 one edge after release.
